opr1_sequencer: RTL

//  Sequences one PDP-8 Operate Group 1 microinstruction (CLA CLL CMA CML RAR RAL RTx/BSW IAC).

---
 rtl/opr1_if.sv | 32 +++
 rtl/opr1_sequencer.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/opr1_if.sv
// Handshake and datapath-control bundle between the instruction decoder /
// major-state FSM (master) and the Operate Group 1 sequencer (slave).
interface opr1_if;
   logic        CLEAR;
   logic        START;
   logic [11:0] INSTR;
   logic        AC_ALL1;
   logic        BUSY;
   logic        DONE;
   logic        ILLEGAL;
   logic        AC_CLR;
   logic        AC_CMA;
   logic        AC_INC;
   logic        AC_ROT;
   logic        LINK_CLL;
   logic        LINK_CML;
   logic        LINK_SET;
   logic        ROT_LEFT;
   logic        ROT_BSW;

   modport master (
      output CLEAR, START, INSTR, AC_ALL1,
      input  BUSY, DONE, ILLEGAL, AC_CLR, AC_CMA, AC_INC, AC_ROT,
             LINK_CLL, LINK_CML, LINK_SET, ROT_LEFT, ROT_BSW
   );

   modport slave (
      input  CLEAR, START, INSTR, AC_ALL1,
      output BUSY, DONE, ILLEGAL, AC_CLR, AC_CMA, AC_INC, AC_ROT,
             LINK_CLL, LINK_CML, LINK_SET, ROT_LEFT, ROT_BSW
   );
endinterface

// File: rtl/opr1_sequencer.sv
// PDP-8 Operate Group 1 microinstruction sequencer.
// Steps the AC/Link/rotater datapath through clear, complement, increment,
// rotate in PDP-8 event order, skipping phases with nothing to do.
// Build option: define OPR1_BSW_EN to make TWICE with neither RAR nor RAL
// a byte swap (PDP-8/E); otherwise that encoding does no rotate.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for START; all enables low
// CLR   | CLA / CLL
// CMP   | CMA / CML
// INC   | IAC, carry out of AC complements Link
// ROT1  | first rotate (or byte swap)
// ROT2  | second rotate of RTR / RTL
// FIN   | DONE pulse, enables low, back to IDLE
module opr1_sequencer (
   input  logic     CLK,
   input  logic     RESET_N,
   opr1_if.slave    bus
);

`ifdef OPR1_BSW_EN
   localparam logic BSW_EN = 1'b1;
`else
   localparam logic BSW_EN = 1'b0;
`endif

   typedef enum logic [2:0] {
      S_IDLE, S_CLR, S_CMP, S_INC, S_ROT1, S_ROT2, S_FIN
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] fields_q;
   logic [7:0] fsel;
   logic       illegal_q;
   logic       group1, accept;
   logic       need_clr, need_cmp, need_inc, need_rot1, need_rot2;
   logic       single_rot, is_bsw;

   assign group1 = (bus.INSTR[11:8] == 4'b1110);
   assign accept = (state_q == S_IDLE) && bus.START && !bus.CLEAR;

   // In IDLE the phase plan comes straight from INSTR so the first phase
   // can be chosen on the accepting edge; afterwards it comes from the latch.
   assign fsel       = (state_q == S_IDLE) ? bus.INSTR[7:0] : fields_q;
   assign need_clr   = fsel[7] | fsel[6];
   assign need_cmp   = fsel[5] | fsel[4];
   assign need_inc   = fsel[0];
   assign single_rot = fsel[3] ^ fsel[2];
   assign is_bsw     = BSW_EN & fsel[1] & ~fsel[3] & ~fsel[2];
   assign need_rot1  = single_rot | is_bsw;
   assign need_rot2  = fsel[1] & single_rot;

   // State register, latched instruction fields and the ILLEGAL pulse.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q   <= S_IDLE;
         fields_q  <= 8'h00;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         illegal_q <= accept && !group1;
         if (accept && group1) fields_q <= bus.INSTR[7:0];
      end
   end

   // Next state: advance to the next needed phase; CLEAR overrides all.
   always_comb begin
      state_d = state_q;
      if (bus.CLEAR) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: if (bus.START && group1) begin
               if      (need_clr)  state_d = S_CLR;
               else if (need_cmp)  state_d = S_CMP;
               else if (need_inc)  state_d = S_INC;
               else if (need_rot1) state_d = S_ROT1;
               else                state_d = S_FIN;
            end
            S_CLR: begin
               if      (need_cmp)  state_d = S_CMP;
               else if (need_inc)  state_d = S_INC;
               else if (need_rot1) state_d = S_ROT1;
               else                state_d = S_FIN;
            end
            S_CMP: begin
               if      (need_inc)  state_d = S_INC;
               else if (need_rot1) state_d = S_ROT1;
               else                state_d = S_FIN;
            end
            S_INC:   state_d = need_rot1 ? S_ROT1 : S_FIN;
            S_ROT1:  state_d = need_rot2 ? S_ROT2 : S_FIN;
            S_ROT2:  state_d = S_FIN;
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Moore enables decoded from the current phase and latched fields.
   always_comb begin
      bus.BUSY     = (state_q != S_IDLE);
      bus.DONE     = 1'b0;
      bus.ILLEGAL  = illegal_q;
      bus.AC_CLR   = 1'b0;
      bus.AC_CMA   = 1'b0;
      bus.AC_INC   = 1'b0;
      bus.AC_ROT   = 1'b0;
      bus.LINK_CLL = 1'b0;
      bus.LINK_CML = 1'b0;
      bus.LINK_SET = 1'b0;
      bus.ROT_LEFT = 1'b0;
      bus.ROT_BSW  = 1'b0;
      case (state_q)
         S_CLR: begin
            bus.AC_CLR   = fields_q[7];
            bus.LINK_CLL = fields_q[6];
         end
         S_CMP: begin
            bus.AC_CMA   = fields_q[5];
            bus.LINK_CML = fields_q[4];
         end
         S_INC: begin
            bus.AC_INC   = 1'b1;
            bus.LINK_CML = bus.AC_ALL1;
         end
         S_ROT1, S_ROT2: begin
            bus.AC_ROT = 1'b1;
            if (is_bsw) begin
               bus.ROT_BSW = 1'b1;
            end else begin
               bus.LINK_SET = 1'b1;
               bus.ROT_LEFT = fields_q[2];
            end
         end
         S_FIN:   bus.DONE = 1'b1;
         default: ;
      endcase
   end

endmodule
